// File: rtl/bf16_dot_sequencer_pkg.sv
// rtl/bf16_dot_sequencer_pkg.sv - ALU op codes, bf16 constants and FSM encoding shared with alu_bf16
package bf16_dot_sequencer_pkg;

  localparam logic [3:0]  ALU_OP_NONE = 4'b0000;
  localparam logic [3:0]  ALU_OP_ADD  = 4'b0001;
  localparam logic [3:0]  ALU_OP_MUL  = 4'b0010;
  localparam logic [15:0] BF16_ZERO   = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Magnitude bits only: +0 and -0 both count as zero.
  function automatic logic is_bf16_zero(input logic [14:0] mag);
    return mag == 15'd0;
  endfunction

endpackage

// File: rtl/bf16_dot_sequencer_if.sv
// rtl/bf16_dot_sequencer_if.sv - job control, operand stream, ALU port and result stream bundle
interface bf16_dot_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [3:0]       alu_ctrl;
  logic [15:0]      alu_y;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic             busy;

  // Sequencer side.
  modport slave (
    input  start, len, in_valid, in_a, in_b, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, busy
  );

  // Producer/consumer/ALU side.
  modport master (
    output start, len, in_valid, in_a, in_b, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, busy
  );
endinterface

// File: rtl/bf16_dot_sequencer_alu_wait_timer.sv
// rtl/bf16_dot_sequencer_alu_wait_timer.sv - loadable down-counter with done flag for ALU latency waits
module bf16_dot_sequencer_alu_wait_timer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load wins over counting; the counter parks at zero once expired.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bf16_dot_sequencer.sv
// rtl/bf16_dot_sequencer.sv - bf16 dot-product sequencer driving an external alu_bf16 (option: DOT_ZERO_SKIP_EN)
module bf16_dot_sequencer
  import bf16_dot_sequencer_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 8
) (
  input logic                  clock,
  input logic                  reset,
  bf16_dot_sequencer_if.slave  bus
);

  localparam int TW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [TW-1:0] LAT = TW'(ALU_LATENCY);

  state_t           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [15:0]      acc_q;
  logic [15:0]      alu_a_q;
  logic [15:0]      alu_b_q;
  logic [3:0]       alu_ctrl_q;
  logic             out_valid_q;
  logic [15:0]      out_result_q;

  logic xfer;
  logic skip_pair;
  logic timer_load;
  logic timer_done;

  assign xfer = (state_q == ST_LOAD) && bus.in_valid;

`ifdef DOT_ZERO_SKIP_EN
  // A zero operand makes the product a signed zero, which leaves acc unchanged.
  assign skip_pair = is_bf16_zero(bus.in_a[14:0]) || is_bf16_zero(bus.in_b[14:0]);
`else
  assign skip_pair = 1'b0;
`endif

  // The timer is armed on every ALU issue: MUL from LOAD, ADD from MUL.
  assign timer_load = (xfer && !skip_pair) || ((state_q == ST_MUL) && timer_done);

  bf16_dot_sequencer_alu_wait_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (LAT),
    .done_o     (timer_done)
  );

  // Job FSM; every ALU-facing and result output is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      acc_q        <= BF16_ZERO;
      alu_a_q      <= BF16_ZERO;
      alu_b_q      <= BF16_ZERO;
      alu_ctrl_q   <= ALU_OP_NONE;
      out_valid_q  <= 1'b0;
      out_result_q <= BF16_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            remaining_q <= bus.len;
            acc_q       <= BF16_ZERO;
            if (bus.len == '0) begin
              out_result_q <= BF16_ZERO;
              out_valid_q  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (skip_pair) begin
              remaining_q <= remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                out_result_q <= acc_q;
                out_valid_q  <= 1'b1;
                state_q      <= ST_DONE;
              end
            end else begin
              alu_a_q    <= bus.in_a;
              alu_b_q    <= bus.in_b;
              alu_ctrl_q <= ALU_OP_MUL;
              state_q    <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          // alu_b_q doubles as the product register for the add.
          if (timer_done) begin
            alu_a_q    <= acc_q;
            alu_b_q    <= bus.alu_y;
            alu_ctrl_q <= ALU_OP_ADD;
            state_q    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (timer_done) begin
            acc_q       <= bus.alu_y;
            remaining_q <= remaining_q - CNT_W'(1);
            alu_ctrl_q  <= ALU_OP_NONE;
            if (remaining_q == CNT_W'(1)) begin
              out_result_q <= bus.alu_y;
              out_valid_q  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          alu_ctrl_q <= ALU_OP_NONE;
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

endmodule

// File: tb/tb_bf16_dot_sequencer.sv
// tb/tb_bf16_dot_sequencer.sv - randomized bench with bf16 ALU model and dot-product reference
module tb_bf16_dot_sequencer;
  import bf16_dot_sequencer_pkg::*;

  localparam int L     = 2;
  localparam int CNT_W = 8;
`ifdef DOT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bf16_dot_sequencer_if #(.CNT_W(CNT_W)) bus ();

  bf16_dot_sequencer #(.ALU_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] pa[$];
  logic [15:0] pb[$];
  logic [15:0] exp_q[$];
  logic [3:0]  ctrl_log[$];
  int mul_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // bf16 <-> double; bf16 values in use are normal or zero.
  function automatic real bf_to_r(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:7] == 8'd0) d = {b[15], 63'd0};
    else d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r_to_bf(input real r);
    logic [63:0] d;
    int e;
    logic [14:0] mag;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 15'd0};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 15'd0};
    if (e >= 255) return {d[63], 8'hff, 7'd0};
    mag = {e[7:0], d[51:45]};
    if (d[44] && ((|d[43:0]) || mag[0])) mag = mag + 15'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    case (op)
      ALU_OP_MUL: return r_to_bf(bf_to_r(a) * bf_to_r(b));
      ALU_OP_ADD: return r_to_bf(bf_to_r(a) + bf_to_r(b));
      default:    return 16'h7fc1;
    endcase
  endfunction

  function automatic logic [15:0] model_job();
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < pa.size(); i++)
      acc = alu_model(acc, alu_model(pa[i], pb[i], ALU_OP_MUL), ALU_OP_ADD);
    return acc;
  endfunction

  function automatic bit is_z(input logic [15:0] v);
    return v[14:0] == 15'd0;
  endfunction

  function automatic logic [15:0] rnd_bf();
    if ($urandom_range(0, 6) == 0) return {1'($urandom_range(0, 1)), 15'd0};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  // External ALU stand-in: L-deep pipeline.
  logic [15:0] alu_pipe [L];
  always @(posedge clock) begin
    alu_pipe[0] <= alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_y = alu_pipe[L-1];

  // Per-cycle compare process, sampled 1 time unit after the falling edge.
  initial begin
    logic        prev_valid, prev_ready, prev_rst;
    logic [15:0] prev_res, prev_a, prev_b;
    logic [3:0]  prev_ctrl;
    int          hold;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_rst = 1'b1;
    prev_res = '0; prev_a = '0; prev_b = '0; prev_ctrl = '0; hold = 0;
    forever begin
      @(negedge clock); #1;
      if (reset) begin
        prev_rst = 1'b1;
        prev_valid = 1'b0;
      end else begin
        chk("in_ready_implies_busy", {31'd0, bus.in_ready && !bus.busy}, 32'd0);
        chk("in_ready_excl_out_valid", {31'd0, bus.in_ready && bus.out_valid}, 32'd0);
        if (prev_valid && !prev_ready) begin
          chk("out_valid_held", {31'd0, bus.out_valid}, 32'd1);
          chk("out_result_held", {16'd0, bus.out_result}, {16'd0, prev_res});
        end
        if (bus.out_valid && !prev_valid) begin
          if (exp_q.size() == 0) fail("unexpected_out_valid");
          else chk("dot_result", {16'd0, bus.out_result}, {16'd0, exp_q.pop_front()});
        end
        if (bus.alu_a == prev_a && bus.alu_b == prev_b && bus.alu_ctrl == prev_ctrl) begin
          hold++;
        end else begin
          if (prev_ctrl != ALU_OP_NONE && !prev_rst) chk("alu_hold_cycles", hold, L + 1);
          if (bus.alu_ctrl != ALU_OP_NONE) ctrl_log.push_back(bus.alu_ctrl);
          if (bus.alu_ctrl == ALU_OP_MUL) mul_cnt++;
          hold = 1;
        end
        prev_rst = 1'b0;
        prev_valid = bus.out_valid;
      end
      prev_ready = bus.out_ready;
      prev_res   = bus.out_result;
      prev_a     = bus.alu_a;
      prev_b     = bus.alu_b;
      prev_ctrl  = bus.alu_ctrl;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, bus.out_result}, 32'h0);
    chk("rst_alu_a", {16'd0, bus.alu_a}, 32'h0);
    chk("rst_alu_b", {16'd0, bus.alu_b}, 32'h0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  // Runs one job over pa/pb; gaps are LOAD cycles with in_valid low.
  task automatic run_job(input int gap_lo, input int gap_hi, input int ord_lo, input int ord_hi,
                         input bit pulse, input bit abort2, input bit check_lat);
    int n, idx, gap, cyc, exp_mul, exp_cyc, d;
    n = pa.size();
    exp_q.push_back(model_job());
    exp_mul = 0;
    exp_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (SKIP && (is_z(pa[i]) || is_z(pb[i]))) exp_cyc += 1;
      else begin
        exp_mul++;
        exp_cyc += 1 + 2 * (L + 1);
      end
    end
    @(negedge clock);
    bus.start = 1'b1;
    bus.len = CNT_W'(n);
    mul_cnt = 0;
    ctrl_log.delete();
    @(negedge clock);
    bus.start = 1'b0;
    idx = 0;
    cyc = 0;
    gap = $urandom_range(gap_lo, gap_hi);
    while (!bus.out_valid && cyc < 3000) begin
      if (abort2 && idx == 2 && bus.alu_ctrl == ALU_OP_ADD) break;
      bus.start = pulse && (cyc == 4);
      bus.len = (pulse && cyc == 4) ? CNT_W'(3) : CNT_W'(n);
      if (idx < n && gap == 0) begin
        bus.in_valid = 1'b1;
        bus.in_a = pa[idx];
        bus.in_b = pb[idx];
        if (bus.in_ready) begin
          idx++;
          gap = $urandom_range(gap_lo, gap_hi);
        end
      end else begin
        if (gap > 0 && bus.in_ready) gap--;
        bus.in_valid = !bus.in_ready && ($urandom_range(0, 1) == 1);
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    if (cyc >= 3000) begin
      fail("timeout_waiting_out_valid");
      return;
    end
    if (abort2) begin
      reset = 1'b1;
      @(posedge clock); #1;
      chk_reset_outputs();
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      return;
    end
    chk("pairs_consumed", idx, n);
    if (check_lat) chk("job_latency", cyc, exp_cyc);
    d = $urandom_range(ord_lo, ord_hi);
    repeat (d) @(negedge clock);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    @(negedge clock);
    chk("out_valid_dropped", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_after_accept", {31'd0, bus.busy}, 32'd0);
    chk("mul_issue_count", mul_cnt, exp_mul);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_outputs();
    reset = 1'b0;

    pa = '{16'hbf40}; pb = '{16'h3fe0};
    chk("model_single", {16'd0, model_job()}, 32'hbfa8);
    run_job(0, 0, 3, 3, 1'b0, 1'b0, 1'b1);
    chk("ctrl_seq_len", ctrl_log.size(), 2);
    if (ctrl_log.size() == 2) begin
      chk("ctrl_seq_first", {28'd0, ctrl_log[0]}, {28'd0, ALU_OP_MUL});
      chk("ctrl_seq_second", {28'd0, ctrl_log[1]}, {28'd0, ALU_OP_ADD});
    end

    pa = '{16'hbf40, 16'h3f80}; pb = '{16'h3fe0, 16'h3f80};
    chk("model_two", {16'd0, model_job()}, 32'hbea0);
    run_job(0, 0, 0, 2, 1'b0, 1'b0, 1'b1);

    pa = '{16'h3f80, 16'h3f80}; pb = '{16'h3f80, 16'h3f80};
    chk("model_ones", {16'd0, model_job()}, 32'h4000);
    run_job(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    run_job(3, 3, 1, 1, 1'b1, 1'b0, 1'b0);

    pa.delete(); pb.delete();
    run_job(0, 0, 2, 2, 1'b0, 1'b0, 1'b1);
    chk("len0_no_alu_activity", ctrl_log.size(), 0);

    pa = '{16'h3f80, 16'h4000, 16'h4040}; pb = '{16'h3f80, 16'h4000, 16'h4040};
    run_job(0, 1, 0, 0, 1'b0, 1'b1, 1'b0);
    pa = '{16'h3f80}; pb = '{16'hbf80};
    chk("model_neg", {16'd0, model_job()}, 32'hbf80);
    run_job(0, 0, 0, 1, 1'b0, 1'b0, 1'b1);

    pa = '{16'h0000, 16'h3f80}; pb = '{16'h3f80, 16'h3f80};
    chk("model_zero_pair", {16'd0, model_job()}, 32'h3f80);
    run_job(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, 6);
      pa.delete(); pb.delete();
      for (int k = 0; k < n; k++) begin
        pa.push_back(rnd_bf());
        pb.push_back(rnd_bf());
      end
      if (j % 3 == 0) run_job(0, 0, 0, 3, 1'b0, 1'b0, 1'b1);
      else run_job(0, 3, 0, 4, (j % 4) == 1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bf16_dot_sequencer.md
Name: bf16_dot_sequencer

Overview:
Control stage directly upstream of alu_bf16. It accepts a stream of bf16 operand pairs over a valid/ready handshake and time-multiplexes one alu_bf16 instance, which sits outside this block. For each pair it issues a multiply, then adds the product into a running accumulator. After len pairs it presents the bf16 dot product on a valid/ready output.

Parameters:
ALU_LATENCY, 1, clock cycles from alu_a/alu_b/alu_ctrl stable to alu_y valid (must be ≥1).
CNT_W, 8, width of the length and element counters.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  1-cycle pulse; begins a job, sampled only in IDLE
len  in  CNT_W  number of pairs for the job, sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts a pair this cycle
in_a  in  16  bf16 operand a
in_b  in  16  bf16 operand b
alu_a  out  16  to alu_bf16 a
alu_b  out  16  to alu_bf16 b
alu_ctrl  out  4  4'b0010 = MUL, 4'b0001 = ADD, 4'b0000 = idle
alu_y  in  16  alu_bf16 result
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_result  out  16  bf16 dot product
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset values: in_ready=0, out_valid=0, out_result=16'h0000, alu_a=alu_b=16'h0000, alu_ctrl=4'b0000, busy=0, accumulator=16'h0000, state=IDLE.
- FSM states: IDLE, LOAD, MUL, ACC, DONE.
- IDLE:
  - On start, latch len into remaining and clear acc to 16'h0000.
  - If len==0, go to DONE with result 16'h0000. Otherwise go to LOAD.
- LOAD:
  - in_ready=1 combinationally, in this state only.
  - A transfer occurs when in_valid && in_ready.
  - On transfer, register in_a/in_b onto alu_a/alu_b, set alu_ctrl=MUL, load wait counter with ALU_LATENCY, go to MUL.
- MUL:
  - Hold the ALU inputs and decrement the wait counter.
  - When it reaches 0, capture alu_y as the product.
  - Then drive alu_a=acc, alu_b=product, alu_ctrl=ADD, reload the wait counter, go to ACC.
- ACC:
  - Hold the ALU inputs and count down.
  - At 0, capture alu_y into acc and decrement remaining.
  - If remaining becomes 0, go to DONE; else go to LOAD.
- DONE:
  - out_result=acc, out_valid=1, alu_ctrl=4'b0000.
  - Hold until out_ready, then go to IDLE.
  - out_valid drops the cycle after acceptance.
- Per-pair latency: 1 LOAD cycle + (ALU_LATENCY+1) cycles in MUL + (ALU_LATENCY+1) cycles in ACC.
- ALU inputs never change while a wait counter is nonzero.
- start in any state other than IDLE is ignored; there is no queuing.
- out_result and out_valid are stable under backpressure.
- Reset asserted mid-job returns to IDLE on the next edge. The partial accumulation is discarded and no out_valid is produced.
- Numeric behaviour (rounding, zero, sign) is exactly that of alu_bf16. This block adds no arithmetic.
- in_valid outside LOAD is ignored; no data is consumed.

Optional Feature:
DOT_ZERO_SKIP_EN:
- Defined: in LOAD, a pair where either operand has bits[14:0]==0 (±0) is accepted and remaining is decremented. MUL and ACC are skipped, and acc is unchanged. Cost is 1 cycle.
- Not defined: every pair goes through MUL and ACC.
- The final result is identical in both builds.

Decomposition:
- Shared package (shared with the ALU): ALU op constants ALU_OP_NONE=4'b0000, ALU_OP_ADD=4'b0001, ALU_OP_MUL=4'b0010; BF16_ZERO=16'h0000; FSM state encoding.
- Sub-module: alu_wait_timer. It is a loadable down-counter with a done flag, reused by the MUL and ACC states.
- alu_bf16 is instantiated alongside this block in the bench and wrapper, not inside it.

Test Plan:
- start, len=1, pair (bf40, 3fe0) → alu_ctrl sequence MUL then ADD; out_result=16'hbfa8; out_valid held until out_ready.
- len=2, pairs (bf40,3fe0),(3f80,3f80) → out_result=16'hbea0.
- len=2, pairs (3f80,3f80),(3f80,3f80) → 16'h4000; in_valid stalled 3 cycles between pairs → same result, in_ready low outside LOAD.
- len=0 → out_valid on the cycle after start, out_result=16'h0000, no ALU activity; start pulses while busy are ignored.
- Reset asserted during ACC of the second pair of a 3-pair job → all outputs return to reset values next cycle; a new len=1 job with (3f80,bf80) gives 16'hbf80.
- With DOT_ZERO_SKIP_EN: pairs (0000,3f80),(3f80,3f80) → 16'h3f80, with exactly one MUL issue counted.
